wide_alu_sequencer: RTL
=======================

WIDE_ALU_SEQUENCER -- requirements
Module: wide_alu_sequencer

Interface
REQ-001: The module SHALL have parameter n, default 8, giving the slice width; operands and result SHALL be 2n bits wide.
REQ-002: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  operation request valid.
REQ-005: in_ready  output  1  sequencer can accept a request.
REQ-006: op  input  3  {ctrl[1:0], cin} encoding, using the same function table as the team's n-bit ALU (000 add, 001 sub, 010 or, 011 or-not-B, 100 and, 101 and-not-B, 110 not-A, 111 not-B).
REQ-007: a, b  input  2n  operands, sampled only on acceptance.
REQ-008: out_valid  output  1  result valid.
REQ-009: out_ready  input  1  consumer accepts the result.
REQ-010: f  output  2n  result.
REQ-011: cout, v, z  output  1 each  carry-out, signed overflow, and zero flag.

Function
REQ-012: A request SHALL be accepted on any cycle in which in_valid and in_ready are both 1; a, b and op SHALL be registered at that cycle.
REQ-013: The FSM states SHALL be IDLE, LO, HI and DONE. Transitions: IDLE->LO on accept; LO->HI unconditionally; HI->DONE unconditionally; DONE->IDLE when out_ready=1; otherwise DONE SHALL hold.
REQ-014: in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; latency SHALL be accept at edge k and out_valid high from cycle k+3.
REQ-015: In LO, the slice ALU SHALL be driven with a[n-1:0], b[n-1:0], ctrl=op[2:1] and cin=op[0]; the slice f, cout and z SHALL be captured as f_lo, c_lo and z_lo.
REQ-016: In HI for arithmetic ops (op[2:1]=00), the slice SHALL get cin=c_lo and b_drive = b[2n-1:n] XOR replicate(op[0] XOR c_lo), so the high half computes a_hi + (op[0] ? ~b_hi : b_hi) + c_lo.
REQ-017: In HI for logic ops, the slice SHALL get a[2n-1:n], b[2n-1:n], ctrl=op[2:1] and cin=op[0].
REQ-018: In DONE, f SHALL equal {f_hi, f_lo} and z SHALL equal z_lo AND z_hi.
REQ-019: For arithmetic ops, cout and v SHALL take the slice cout and v from HI; for logic ops, cout and v SHALL be 0.
REQ-020: f, cout, v and z SHALL be held stable throughout DONE regardless of in_valid.
REQ-021: in_valid asserted outside IDLE SHALL be ignored, and no request SHALL be lost or double-accepted.
REQ-022: A new request SHALL NOT be accepted in the same cycle that DONE is exited; earliest re-accept SHALL be the following cycle in IDLE.

Reset
REQ-023: While rst=1, the state SHALL go to IDLE and out_valid, f, cout, v, z, f_lo, c_lo and z_lo SHALL be 0; in_ready SHALL be 1 from the first cycle after rst is released.
REQ-024: rst asserted in LO, HI or DONE SHALL abort the operation with no result presented, and rst SHALL take priority over all handshakes.

Structure
REQ-025: A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, LO=1, HI=2, DONE=3) and the op-code constants.
REQ-026: Exactly one sub-module SHALL be instantiated: the team's n-bit ALU (n_bit_ALU), with width n, time-multiplexed across LO and HI; no second adder SHALL exist.

Verification
REQ-027: n=8, add a=0x00FF, b=0x0001 -> f=0x0100, cout=0, v=0, z=0, out_valid 3 cycles after accept.
REQ-028: sub a=0x8000, b=0x0001 -> f=0x7FFF, cout=1, v=1, z=0.
REQ-029: sub a=0x1234, b=0x1234 -> f=0x0000, cout=1, v=0, z=1; and-not-B a=0xF0F0, b=0xFFFF -> f=0x0000, z=1, cout=0, v=0.
REQ-030: Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> f/flags stable, in_ready=0, no second accept; release -> one cycle later IDLE and next request accepted.
REQ-031: Assert rst during HI of an add 0xFFFF+0x0001 -> out_valid never rises, outputs 0, in_ready=1 after release; a following add 0x0001+0x0001 -> f=0x0002.
REQ-032: Back-to-back requests with out_ready tied 1 -> one result every 4 cycles, each matching a 16-bit reference model over randomized ops.

Source files
------------

// File: rtl/wide_alu_sequencer_pkg.sv
// rtl/wide_alu_sequencer_pkg.sv - shared FSM encoding and op-code constants for the wide ALU sequencer
package wide_alu_sequencer_pkg;

  // Sequencer states: one slice pass per half, then hold the result until consumed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Op codes are {ctrl[1:0], cin}; cin selects the B-inverted variant of each function.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ORN  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  localparam logic [1:0] CTRL_ARITH = 2'b00;

  // True for add/sub, the only ops whose carry ripples between slices.
  function automatic logic is_arith(input logic [2:0] op);
    return op[2:1] == CTRL_ARITH;
  endfunction

endpackage

// File: rtl/n_bit_ALU.sv
// rtl/n_bit_ALU.sv - n-bit slice ALU with add/sub and bitwise functions selected by {ctrl, cin}
module n_bit_ALU
  import wide_alu_sequencer_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic [1:0]   ctrl_i,
  input  logic         cin_i,
  output logic [n-1:0] f_o,
  output logic         cout_o,
  output logic         v_o,
  output logic         z_o
);

  logic [n-1:0] b_eff;
  logic [n:0]   sum;

  // Arithmetic path: cin both inverts B and supplies the +1, so cin=1 gives a - b.
  always_comb begin
    b_eff = cin_i ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{n{1'b0}}, cin_i};
  end

  // Function select; carry and overflow are meaningful only for add/sub.
  always_comb begin
    f_o    = '0;
    cout_o = 1'b0;
    v_o    = 1'b0;
    unique case ({ctrl_i, cin_i})
      OP_ADD, OP_SUB: begin
        f_o    = sum[n-1:0];
        cout_o = sum[n];
        v_o    = (a_i[n-1] == b_eff[n-1]) && (sum[n-1] != a_i[n-1]);
      end
      OP_OR:   f_o = a_i | b_i;
      OP_ORN:  f_o = a_i | ~b_i;
      OP_AND:  f_o = a_i & b_i;
      OP_ANDN: f_o = a_i & ~b_i;
      OP_NOTA: f_o = ~a_i;
      OP_NOTB: f_o = ~b_i;
      default: f_o = '0;
    endcase
  end

  assign z_o = ~|f_o;

endmodule

// File: rtl/wide_alu_sequencer.sv
// rtl/wide_alu_sequencer.sv - 2n-bit ALU built by running one n-bit slice over the low then high half
module wide_alu_sequencer
  import wide_alu_sequencer_pkg::*;
#(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [2*n-1:0] a,
  input  logic [2*n-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] f,
  output logic           cout,
  output logic           v,
  output logic           z
);

  state_e         state_q;
  logic [2:0]     op_q;
  logic [2*n-1:0] a_q;
  logic [2*n-1:0] b_q;
  logic [n-1:0]   f_lo_q;
  logic           c_lo_q;
  logic           z_lo_q;
  logic [2*n-1:0] f_q;
  logic           cout_q;
  logic           v_q;
  logic           z_q;
  logic           in_ready_q;
  logic           out_valid_q;

  logic [n-1:0]   alu_a;
  logic [n-1:0]   alu_b;
  logic [1:0]     alu_ctrl;
  logic           alu_cin;
  logic [n-1:0]   alu_f;
  logic           alu_cout;
  logic           alu_v;
  logic           alu_z;

  logic [2*n-1:0] f_d;
  logic           cout_d;
  logic           v_d;
  logic           z_d;

  // Slice input mux: low half by default; in HI the carry from LO is chained in.
  // The slice inverts B whenever cin=1, so B is pre-XORed with (op[0]^c_lo) to
  // leave an effective operand of b_hi ^ op[0] while cin carries c_lo.
  always_comb begin
    alu_a    = a_q[n-1:0];
    alu_b    = b_q[n-1:0];
    alu_ctrl = op_q[2:1];
    alu_cin  = op_q[0];
    if (state_q == ST_HI) begin
      alu_a = a_q[2*n-1:n];
      if (is_arith(op_q)) begin
        alu_b   = b_q[2*n-1:n] ^ {n{op_q[0] ^ c_lo_q}};
        alu_cin = c_lo_q;
      end else begin
        alu_b = b_q[2*n-1:n];
      end
    end
  end

  n_bit_ALU #(
    .n(n)
  ) u_slice (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .ctrl_i(alu_ctrl),
    .cin_i (alu_cin),
    .f_o   (alu_f),
    .cout_o(alu_cout),
    .v_o   (alu_v),
    .z_o   (alu_z)
  );

  // Final result assembled from the stored low half and the live high-half slice.
  always_comb begin
    f_d    = {alu_f, f_lo_q};
    z_d    = z_lo_q & alu_z;
    cout_d = is_arith(op_q) ? alu_cout : 1'b0;
    v_d    = is_arith(op_q) ? alu_v : 1'b0;
  end

  // Sequencer FSM with registered handshakes and result; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_lo_q      <= '0;
      c_lo_q      <= 1'b0;
      z_lo_q      <= 1'b0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            a_q        <= a;
            b_q        <= b;
            in_ready_q <= 1'b0;
            state_q    <= ST_LO;
          end
        end
        ST_LO: begin
          f_lo_q  <= alu_f;
          c_lo_q  <= alu_cout;
          z_lo_q  <= alu_z;
          state_q <= ST_HI;
        end
        ST_HI: begin
          f_q         <= f_d;
          cout_q      <= cout_d;
          v_q         <= v_d;
          z_q         <= z_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign cout      = cout_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule
